traffic_phase_scheduler: RTL and testbench

//  Demand-driven phase scheduler for the 4-head junction (highway 1/2, farmway 1/2). Latches vehicle

---
 rtl/traffic_phase_scheduler.sv | 164 ++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven phase scheduler for a 4-head highway/farmway junction.
// Optional emergency highway preempt is compiled in with `define PREEMPT_EN.
module traffic_phase_scheduler #(
    parameter int unsigned CW         = 5,
    parameter int unsigned T_ALLRED   = 1,
    parameter int unsigned T_PREP     = 2,
    parameter int unsigned T_YELLOW   = 2,
    parameter int unsigned T_HW_MIN   = 10,
    parameter int unsigned T_SIDE_MIN = 5,
    parameter int unsigned T_SIDE_MAX = 15
) (
    input  logic          clk,
    input  logic          Rst,
    input  logic          go,
    input  logic [2:0]    req,
`ifdef PREEMPT_EN
    input  logic          preempt,
`endif
    output logic [1:0]    highwaySignal1,
    output logic [1:0]    highwaySignal2,
    output logic [1:0]    farmwaysignal1,
    output logic [1:0]    farmwaysignal2,
    output logic [1:0]    phase,
    output logic [1:0]    presentState,
    output logic [CW-1:0] count,
    output logic [2:0]    served
);

    localparam logic [1:0] S_ALLRED = 2'd0;
    localparam logic [1:0] S_PREP   = 2'd1;
    localparam logic [1:0] S_GREEN  = 2'd2;
    localparam logic [1:0] S_YELLOW = 2'd3;

    localparam logic [1:0] PH_HW  = 2'd0;
    localparam logic [1:0] PH_FW1 = 2'd1;
    localparam logic [1:0] PH_FW2 = 2'd2;
    localparam logic [1:0] PH_HW2 = 2'd3;

    localparam logic [1:0] C_GREEN  = 2'b00;
    localparam logic [1:0] C_YELLOW = 2'b01;
    localparam logic [1:0] C_RED    = 2'b10;
    localparam logic [1:0] C_RY     = 2'b11;

    localparam logic [CW-1:0] CNT_MAX      = {CW{1'b1}};
    localparam logic [CW-1:0] ALLRED_LAST  = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] PREP_LAST    = CW'(T_PREP - 1);
    localparam logic [CW-1:0] YELLOW_LAST  = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] HW_MIN_LAST  = CW'(T_HW_MIN - 1);
    localparam logic [CW-1:0] SIDE_MIN_LAST = CW'(T_SIDE_MIN - 1);
    localparam logic [CW-1:0] SIDE_MAX_LAST = CW'(T_SIDE_MAX - 1);

    logic [2:0]    pend, pend_n;
    logic [1:0]    state_n, phase_n;
    logic [CW-1:0] count_n;
    logic [2:0]    served_n;
    logic [1:0]    side_idx;
    logic [1:0]    nxt_ph;
    logic          side_green;
    logic          preempt_act;

`ifdef PREEMPT_EN
    assign preempt_act = preempt;
`else
    assign preempt_act = 1'b0;
`endif

    assign side_idx   = phase - 2'd1;
    assign side_green = (presentState == S_GREEN) && (phase != PH_HW);

    // Next phase: lowest pending side phase numbered above the outgoing one, else highway.
    always_comb begin
        nxt_ph = PH_HW;
        for (int i = 3; i >= 1; i--) begin
            if ((2'(i) > phase) && pend[i-1]) begin
                nxt_ph = 2'(i);
            end
        end
        if (preempt_act) begin
            nxt_ph = PH_HW;
        end
    end

    // Next-state, phase, timer, demand latch and served pulse.
    always_comb begin
        state_n  = presentState;
        phase_n  = phase;
        count_n  = count;
        served_n = 3'b000;
        pend_n   = pend | req;
        if (side_green) begin
            pend_n[side_idx] = 1'b0;
        end
        if (go) begin
            count_n = (count == CNT_MAX) ? count : count + CW'(1);
            case (presentState)
                S_ALLRED: begin
                    if (count == ALLRED_LAST) begin
                        state_n = S_PREP;
                        phase_n = nxt_ph;
                    end
                end
                S_PREP: begin
                    if (count == PREP_LAST) begin
                        state_n = S_GREEN;
                        if (phase != PH_HW) begin
                            served_n[side_idx] = 1'b1;
                            pend_n[side_idx]   = 1'b0;
                        end
                    end
                end
                S_GREEN: begin
                    if (phase == PH_HW) begin
                        if ((count >= HW_MIN_LAST) && (pend != 3'b000) && !preempt_act) begin
                            state_n = S_YELLOW;
                        end
                    end else if ((count == SIDE_MAX_LAST) || preempt_act ||
                                 ((count >= SIDE_MIN_LAST) && !req[side_idx])) begin
                        state_n = S_YELLOW;
                    end
                end
                default: begin
                    if (count == YELLOW_LAST) begin
                        state_n = S_ALLRED;
                    end
                end
            endcase
            if (state_n != presentState) begin
                count_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            presentState <= S_ALLRED;
            phase        <= PH_HW;
            count        <= '0;
            pend         <= 3'b000;
            served       <= 3'b000;
        end else begin
            presentState <= state_n;
            phase        <= phase_n;
            count        <= count_n;
            pend         <= pend_n;
            served       <= served_n;
        end
    end

    // Head decode: only the active phase's heads leave red.
    logic [1:0] act_code;
    always_comb begin
        case (presentState)
            S_PREP:   act_code = C_RY;
            S_GREEN:  act_code = C_GREEN;
            S_YELLOW: act_code = C_YELLOW;
            default:  act_code = C_RED;
        endcase
        highwaySignal1 = (phase == PH_HW) ? act_code : C_RED;
        highwaySignal2 = ((phase == PH_HW) || (phase == PH_HW2)) ? act_code : C_RED;
        farmwaysignal1 = (phase == PH_FW1) ? act_code : C_RED;
        farmwaysignal2 = (phase == PH_FW2) ? act_code : C_RED;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler; preempt scenario runs when PREEMPT_EN is defined.
module tb_traffic_phase_scheduler;

    localparam int unsigned CW = 5;

    // {highwaySignal1, highwaySignal2, farmwaysignal1, farmwaysignal2}
    localparam logic [7:0] ALLR   = 8'b10101010;
    localparam logic [7:0] HW_RY  = 8'b11111010;
    localparam logic [7:0] HW_G   = 8'b00001010;
    localparam logic [7:0] HW_Y   = 8'b01011010;
    localparam logic [7:0] FW1_RY = 8'b10101110;
    localparam logic [7:0] FW1_G  = 8'b10100010;
    localparam logic [7:0] FW1_Y  = 8'b10100110;
    localparam logic [7:0] FW2_G  = 8'b10101000;
    localparam logic [7:0] HW2_RY = 8'b10111010;
    localparam logic [7:0] HW2_G  = 8'b10001010;

    logic          clk = 1'b0;
    logic          Rst;
    logic          go;
    logic [2:0]    req;
    logic          preempt;
    logic [1:0]    highwaySignal1, highwaySignal2, farmwaysignal1, farmwaysignal2;
    logic [1:0]    phase, presentState;
    logic [CW-1:0] count;
    logic [2:0]    served;

    int tests = 0;
    int fails = 0;

    traffic_phase_scheduler #(.CW(CW)) dut (
        .clk            (clk),
        .Rst            (Rst),
        .go             (go),
        .req            (req),
`ifdef PREEMPT_EN
        .preempt        (preempt),
`endif
        .highwaySignal1 (highwaySignal1),
        .highwaySignal2 (highwaySignal2),
        .farmwaysignal1 (farmwaysignal1),
        .farmwaysignal2 (farmwaysignal2),
        .phase          (phase),
        .presentState   (presentState),
        .count          (count),
        .served         (served)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_sp(input string tag, input int st, input int ph);
        check({tag, ".state"}, 32'(presentState), st);
        check({tag, ".phase"}, 32'(phase), ph);
    endtask

    task automatic chk_heads(input string tag, input logic [7:0] exp);
        check({tag, ".heads"},
              32'({highwaySignal1, highwaySignal2, farmwaysignal1, farmwaysignal2}), 32'(exp));
    endtask

    task automatic wait_state(input string tag, input int st, input int ph, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1);
            if (32'(presentState) == st && 32'(phase) == ph) hit = 1'b1;
        end
        check({tag, ".reached"}, 32'(hit), 1);
    endtask

    initial begin
        Rst = 1'b1; go = 1'b1; req = 3'b000; preempt = 1'b0;

        // 1: reset, startup into highway rest green
        tick(2);
        chk_heads("rst", ALLR);
        chk_sp("rst", 0, 0);
        check("rst.count", 32'(count), 0);
        check("rst.served", 32'(served), 0);
        Rst = 1'b0;
        tick(1);
        chk_sp("boot_prep", 1, 0);
        chk_heads("boot_prep", HW_RY);
        tick(2);
        chk_sp("boot_green", 2, 0);
        chk_heads("boot_green", HW_G);
        tick(100);
        chk_heads("hw_rest", HW_G);
        check("hw_rest.count_sat", 32'(count), 31);

        // 2: single FW1 request
        req = 3'b001; tick(1); req = 3'b000;
        chk_sp("t2_latch", 2, 0);
        tick(1);
        chk_sp("t2_hwy", 3, 0);
        chk_heads("t2_hwy", HW_Y);
        tick(2);
        chk_sp("t2_allred", 0, 0);
        chk_heads("t2_allred", ALLR);
        tick(1);
        chk_sp("t2_prep", 1, 1);
        chk_heads("t2_prep", FW1_RY);
        tick(2);
        chk_sp("t2_green", 2, 1);
        chk_heads("t2_green", FW1_G);
        check("t2_green.served", 32'(served), 1);
        check("t2_green.count", 32'(count), 0);
        tick(1);
        check("t2_served_off", 32'(served), 0);
        tick(3);
        chk_sp("t2_green_last", 2, 1);
        check("t2_green_last.count", 32'(count), 4);
        tick(1);
        chk_sp("t2_fw1y", 3, 1);
        chk_heads("t2_fw1y", FW1_Y);
        tick(2);
        chk_sp("t2_allred2", 0, 1);
        tick(1);
        chk_sp("t2_back_hw", 1, 0);
        tick(2);
        chk_sp("t2_hw_green", 2, 0);

        // 3: FW2 held -> max green, relatch, re-serve after highway min green
        req = 3'b010;
        tick(9);
        chk_sp("t3_hw_min", 2, 0);
        check("t3_hw_min.count", 32'(count), 9);
        tick(1);
        chk_sp("t3_hwy", 3, 0);
        tick(3);
        chk_sp("t3_prep", 1, 2);
        tick(2);
        chk_heads("t3_green", FW2_G);
        check("t3_green.served", 32'(served), 2);
        tick(14);
        chk_sp("t3_max_last", 2, 2);
        check("t3_max_last.count", 32'(count), 14);
        tick(1);
        chk_sp("t3_fw2y", 3, 2);
        tick(1);
        req = 3'b000;
        tick(2);
        chk_sp("t3_to_hw", 1, 0);
        tick(2);
        tick(9);
        chk_sp("t3_hw_hold", 2, 0);
        check("t3_hw_hold.count", 32'(count), 9);
        tick(1);
        chk_sp("t3_relatched", 3, 0);
        tick(3);
        chk_sp("t3_prep2", 1, 2);
        tick(2);
        check("t3_reserve.served", 32'(served), 2);
        tick(5);
        chk_sp("t3_minexit", 3, 2);
        tick(3);
        chk_sp("t3_hw_again", 1, 0);
        tick(2);

        // 4: FW1 + HW2-only, FW2 skipped
        req = 3'b101; tick(1); req = 3'b000;
        tick(8);
        check("t4_hw.count", 32'(count), 9);
        tick(1);
        chk_sp("t4_hwy", 3, 0);
        tick(3);
        chk_sp("t4_fw1prep", 1, 1);
        tick(2);
        check("t4_fw1.served", 32'(served), 1);
        tick(5);
        chk_sp("t4_fw1y", 3, 1);
        tick(3);
        chk_sp("t4_hw2prep", 1, 3);
        chk_heads("t4_hw2prep", HW2_RY);
        tick(2);
        chk_sp("t4_hw2green", 2, 3);
        chk_heads("t4_hw2green", HW2_G);
        check("t4_hw2green.served", 32'(served), 4);
        tick(5);
        chk_sp("t4_hw2y", 3, 3);
        tick(3);
        chk_sp("t4_home", 1, 0);
        tick(2);

        // 5: go freeze and reset mid FW1 green
        req = 3'b001; tick(1); req = 3'b000;
        tick(9);
        chk_sp("t5_hwy", 3, 0);
        tick(5);
        chk_sp("t5_green", 2, 1);
        tick(2);
        go = 1'b0;
        tick(7);
        chk_sp("t5_frozen", 2, 1);
        check("t5_frozen.count", 32'(count), 2);
        chk_heads("t5_frozen", FW1_G);
        go = 1'b1;
        tick(2);
        check("t5_resume.count", 32'(count), 4);
        chk_sp("t5_resume", 2, 1);
        tick(1);
        chk_sp("t5_total5", 3, 1);
        req = 3'b001; tick(1); req = 3'b000;
        wait_state("t5_fw1_again", 2, 1, 60);
        tick(2);
        Rst = 1'b1;
        tick(1);
        chk_heads("t5_rst", ALLR);
        chk_sp("t5_rst", 0, 0);
        check("t5_rst.count", 32'(count), 0);
        Rst = 1'b0;

`ifdef PREEMPT_EN
        // 6: preempt cuts FW1, forces highway, holds highway green
        tick(3);
        chk_sp("t6_hw", 2, 0);
        req = 3'b001; tick(1); req = 3'b000;
        wait_state("t6_fw1", 2, 1, 40);
        tick(1);
        preempt = 1'b1;
        tick(1);
        chk_sp("t6_cut", 3, 1);
        req = 3'b010; tick(1); req = 3'b000;
        tick(2);
        chk_sp("t6_forced_hw", 1, 0);
        tick(2);
        tick(15);
        chk_sp("t6_hold", 2, 0);
        check("t6_hold.count", 32'(count), 15);
        preempt = 1'b0;
        tick(1);
        chk_sp("t6_release", 3, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
